// File: rtl/cl_bram_dp_ctrl.sv
// Dual-port byte-writable RAM with per-port valid/ready requests and credit-limited FWFT read responses.
// Read data reaches the response FIFO RD_LAT edges after accept; req_ready drops when a port's credits run out.
module cl_bram_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_rd_vld,
    output logic [W-1:0] o_rd_dat,
    input  logic         i_rd_rdy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_rd_vld = (r_cnt != '0);
    assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;
    assign w_pop    = o_rd_vld && i_rd_rdy;

    always_ff @(posedge clk) begin
        if (i_wr_vld) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_wr_vld) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)    r_rd_ptr <= ptr_next(r_rd_ptr);
            if (i_wr_vld && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!i_wr_vld && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

module cl_bram_dp_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req_valid,
    output logic                a_req_ready,
    input  logic                a_req_we,
    input  logic [ADDR_W-1:0]   a_req_addr,
    input  logic [DATA_W-1:0]   a_req_wdata,
    input  logic [DATA_W/8-1:0] a_req_wstrb,
    output logic                a_rsp_valid,
    input  logic                a_rsp_ready,
    output logic [DATA_W-1:0]   a_rsp_rdata,
    output logic                a_rsp_err,
    input  logic                b_req_valid,
    output logic                b_req_ready,
    input  logic                b_req_we,
    input  logic [ADDR_W-1:0]   b_req_addr,
    input  logic [DATA_W-1:0]   b_req_wdata,
    input  logic [DATA_W/8-1:0] b_req_wstrb,
    output logic                b_rsp_valid,
    input  logic                b_rsp_ready,
    output logic [DATA_W-1:0]   b_rsp_rdata,
    output logic                b_rsp_err,
    output logic                coll_flag
);
    localparam int NB  = DATA_W / 8;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CRW = $clog2(RSP_DEPTH + 1);

    logic [1:0]        w_vld, w_we, w_rdy, w_acc, w_inr, w_rd, w_wreq, w_wr, w_pop;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic [NB-1:0]     w_wstrb [2];
    logic [AW-1:0]     w_idx   [2];
    logic              w_coll;
    logic [DATA_W:0]   w_rsp_dat_a, w_rsp_dat_b;

    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [CRW-1:0]    r_cred [2];
    logic [RD_LAT-1:0] r_pv   [2];
    logic [RD_LAT-1:0] r_pe   [2];
    logic [DATA_W-1:0] r_pd   [2][RD_LAT];
    logic              r_coll;

    assign w_vld      = {b_req_valid, a_req_valid};
    assign w_we       = {b_req_we, a_req_we};
    assign w_addr[0]  = a_req_addr;
    assign w_addr[1]  = b_req_addr;
    assign w_wdata[0] = a_req_wdata;
    assign w_wdata[1] = b_req_wdata;
    assign w_wstrb[0] = a_req_wstrb;
    assign w_wstrb[1] = b_req_wstrb;
    assign w_pop      = {b_rsp_valid & b_rsp_ready, a_rsp_valid & a_rsp_ready};

    always_comb begin
        w_rdy  = '0;
        w_acc  = '0;
        w_inr  = '0;
        w_rd   = '0;
        w_wreq = '0;
        w_idx  = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            w_rdy[i]  = (r_cred[i] != '0) && !rst;
            w_acc[i]  = w_vld[i] && w_rdy[i];
            w_inr[i]  = (w_addr[i] < ADDR_W'(DEPTH));
            w_idx[i]  = w_addr[i][AW-1:0];
            w_rd[i]   = w_acc[i] && !w_we[i];
            w_wreq[i] = w_acc[i] && w_we[i] && w_inr[i];
        end
    end

    // Same-address write/write: port A wins, port B's whole write is discarded.
    assign w_coll = w_wreq[0] && w_wreq[1] && (w_idx[0] == w_idx[1]);
    assign w_wr   = {w_wreq[1] && !w_coll, w_wreq[0]};

    assign a_req_ready = w_rdy[0];
    assign b_req_ready = w_rdy[1];
    assign coll_flag   = r_coll;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wr[i] && w_wstrb[i][b]) begin
                    r_mem[w_idx[i]][b*8 +: 8] <= w_wdata[i][b*8 +: 8];
                end
            end
        end
    end

    // Nonblocking read of r_mem gives read-first behaviour against same-edge writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            r_pd[i][0] <= (w_rd[i] && w_inr[i]) ? r_mem[w_idx[i]] : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pd[i][s] <= r_pd[i][s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_cred[i] <= CRW'(RSP_DEPTH);
                r_pv[i]   <= '0;
                r_pe[i]   <= '0;
            end
            r_coll <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_rd[i] && !w_pop[i])      r_cred[i] <= r_cred[i] - 1'b1;
                else if (!w_rd[i] && w_pop[i]) r_cred[i] <= r_cred[i] + 1'b1;
                r_pv[i][0] <= w_rd[i];
                r_pe[i][0] <= !w_inr[i];
                for (int s = 1; s < RD_LAT; s++) begin
                    r_pv[i][s] <= r_pv[i][s-1];
                    r_pe[i][s] <= r_pe[i][s-1];
                end
            end
            if (w_coll) r_coll <= 1'b1;
        end
    end

    cl_bram_fifo #(.W(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_rsp_a (
        .clk      (clk),
        .rst      (rst),
        .i_wr_vld (r_pv[0][RD_LAT-1]),
        .i_wr_dat ({r_pe[0][RD_LAT-1], r_pd[0][RD_LAT-1]}),
        .o_rd_vld (a_rsp_valid),
        .o_rd_dat (w_rsp_dat_a),
        .i_rd_rdy (a_rsp_ready)
    );

    cl_bram_fifo #(.W(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_rsp_b (
        .clk      (clk),
        .rst      (rst),
        .i_wr_vld (r_pv[1][RD_LAT-1]),
        .i_wr_dat ({r_pe[1][RD_LAT-1], r_pd[1][RD_LAT-1]}),
        .o_rd_vld (b_rsp_valid),
        .o_rd_dat (w_rsp_dat_b),
        .i_rd_rdy (b_rsp_ready)
    );

    assign a_rsp_err   = w_rsp_dat_a[DATA_W];
    assign a_rsp_rdata = w_rsp_dat_a[DATA_W-1:0];
    assign b_rsp_err   = w_rsp_dat_b[DATA_W];
    assign b_rsp_rdata = w_rsp_dat_b[DATA_W-1:0];
endmodule

// File: tb/tb_cl_bram_dp_ctrl.sv
// Directed bench for cl_bram_dp_ctrl: vector table of single-port accesses plus hand-written
// sequences for cross-port collisions, backpressure and reset with reads in flight.
module tb_cl_bram_dp_ctrl;
    localparam int DW        = 32;
    localparam int DEPTH     = 256;
    localparam int AWID      = 32;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b0;
    logic [AWID-1:0] a_req_addr = '0;
    logic [DW-1:0]   a_req_wdata = '0;
    logic [DW/8-1:0] a_req_wstrb = '0;
    logic            b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
    logic [AWID-1:0] b_req_addr = '0;
    logic [DW-1:0]   b_req_wdata = '0;
    logic [DW/8-1:0] b_req_wstrb = '0;
    logic            a_req_ready, a_rsp_valid, a_rsp_err;
    logic            b_req_ready, b_rsp_valid, b_rsp_err;
    logic [DW-1:0]   a_rsp_rdata, b_rsp_rdata;
    logic            coll_flag;

    cl_bram_dp_ctrl #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AWID), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wstrb(a_req_wstrb),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wstrb(b_req_wstrb),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .b_rsp_err(b_rsp_err),
        .coll_flag(coll_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          p;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_d;
        logic        exp_e;
        string       nm;
    } vec_t;

    vec_t        vq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat, nacc, nrsp;
    logic [31:0] d;
    logic        e, rdy_s, seen;
    logic [31:0] bp_addr [6];
    logic [31:0] bp_exp  [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] exp_d, input logic exp_e,
                       input string nm);
        vec_t v;
        v.p = p; v.we = we; v.addr = addr; v.wd = wd; v.st = st;
        v.exp_d = exp_d; v.exp_e = exp_e; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
        if (p == 0) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_wstrb = st;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_wstrb = st;
        end
    endtask

    task automatic idle();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
        drive(p, we, addr, wd, st);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    // Waits (bounded) for a response on port p, returns it, then pops it with a one-cycle ready.
    task automatic get_rsp(input int p, input string nm, output int l, output logic [31:0] dd,
                           output logic ee);
        logic v;
        l = 0;
        v = (p == 0) ? a_rsp_valid : b_rsp_valid;
        while (!v && l < 32) begin
            @(posedge clk);
            @(negedge clk);
            l++;
            v = (p == 0) ? a_rsp_valid : b_rsp_valid;
        end
        check({nm, " valid"}, 64'(v), 64'd1);
        dd = (p == 0) ? a_rsp_rdata : b_rsp_rdata;
        ee = (p == 0) ? a_rsp_err : b_rsp_err;
        if (p == 0) a_rsp_ready = 1'b1;
        else        b_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst a_req_ready", 64'(a_req_ready), 64'd0);
        check("rst b_req_ready", 64'(b_req_ready), 64'd0);
        check("rst a_rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("rst b_rsp_valid", 64'(b_rsp_valid), 64'd0);
        check("rst a_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
        check("rst a_rsp_err",   64'(a_rsp_err),   64'd0);
        check("rst coll_flag",   64'(coll_flag),   64'd0);
        rst = 1'b0;
        #1;
        check("post-rst a_req_ready", 64'(a_req_ready), 64'd1);
        check("post-rst b_req_ready", 64'(b_req_ready), 64'd1);
        @(negedge clk);

        add(0, 1, 32'd5,          32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "wr5");
        add(0, 0, 32'd5,          32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd5");
        add(0, 1, 32'd7,          32'h11223344, 4'hF, 32'h0,        1'b0, "wr7");
        add(1, 1, 32'd7,          32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "wr7 strb");
        add(1, 0, 32'd7,          32'h0,        4'h0, 32'h11BB33DD, 1'b0, "rd7 strb");
        add(0, 1, 32'd44,         32'hCAFE0044, 4'hF, 32'h0,        1'b0, "wr44");
        add(0, 0, 32'd300,        32'h0,        4'h0, 32'h0,        1'b1, "rd300 oor");
        add(1, 1, 32'd300,        32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, "wr300 oor");
        add(0, 0, 32'd44,         32'h0,        4'h0, 32'hCAFE0044, 1'b0, "rd44 alias");
        add(1, 1, 32'd5,          32'h00000000, 4'h0, 32'h0,        1'b0, "wr5 nostrb");
        add(1, 0, 32'd5,          32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd5 portb");
        add(1, 1, 32'd255,        32'h0BADF00D, 4'hF, 32'h0,        1'b0, "wr255");
        add(0, 0, 32'd255,        32'h0,        4'h0, 32'h0BADF00D, 1'b0, "rd255 top");
        add(0, 0, 32'd256,        32'h0,        4'h0, 32'h0,        1'b1, "rd256 oor");
        add(1, 0, 32'h8000_0005, 32'h0,        4'h0, 32'h0,        1'b1, "rd hi-bit oor");

        foreach (vq[i]) begin
            do_req(vq[i].p, vq[i].we, vq[i].addr, vq[i].wd, vq[i].st);
            if (!vq[i].we) begin
                get_rsp(vq[i].p, vq[i].nm, lat, d, e);
                check({vq[i].nm, " latency"}, 64'(lat), 64'(RD_LAT));
                check({vq[i].nm, " rdata"},   64'(d),   64'(vq[i].exp_d));
                check({vq[i].nm, " err"},     64'(e),   64'(vq[i].exp_e));
            end
        end

        // Cross-port read/write on the same edge: read sees old data, no flag.
        drive(0, 0, 32'd5, 32'h0, 4'h0);
        drive(1, 1, 32'd5, 32'h55555555, 4'hF);
        @(posedge clk);
        @(negedge clk);
        idle();
        get_rsp(0, "rw old", lat, d, e);
        check("rw old rdata", 64'(d), 64'hDEADBEEF);
        check("rw no coll", 64'(coll_flag), 64'd0);
        do_req(0, 0, 32'd5, 32'h0, 4'h0);
        get_rsp(0, "rw new", lat, d, e);
        check("rw new rdata", 64'(d), 64'h55555555);

        // Cross-port read/read on the same edge.
        drive(0, 0, 32'd44, 32'h0, 4'h0);
        drive(1, 0, 32'd44, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        get_rsp(0, "rr a", lat, d, e);
        check("rr a rdata", 64'(d), 64'hCAFE0044);
        get_rsp(1, "rr b", lat, d, e);
        check("rr b rdata", 64'(d), 64'hCAFE0044);

        // Write/write collision with a port-B read still in the pipeline.
        do_req(1, 0, 32'd7, 32'h0, 4'h0);
        drive(0, 1, 32'd9, 32'h00000001, 4'hF);
        drive(1, 1, 32'd9, 32'h00000002, 4'hF);
        @(posedge clk);
        @(negedge clk);
        idle();
        check("coll flag set", 64'(coll_flag), 64'd1);
        get_rsp(1, "coll inflight", lat, d, e);
        check("coll inflight rdata", 64'(d), 64'h11BB33DD);
        do_req(0, 0, 32'd9, 32'h0, 4'h0);
        get_rsp(0, "coll rd9", lat, d, e);
        check("coll rd9 rdata", 64'(d), 64'h00000001);

        // Backpressure: six reads with rsp_ready low, then release.
        bp_addr = '{32'd5, 32'd7, 32'd44, 32'd255, 32'd9, 32'd5};
        bp_exp  = '{32'h55555555, 32'h11BB33DD, 32'hCAFE0044, 32'h0BADF00D, 32'h1, 32'h55555555};
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            rdy_s = a_req_ready;
            drive(0, 0, bp_addr[nacc], 32'h0, 4'h0);
            @(posedge clk);
            if (rdy_s) nacc++;
            @(negedge clk);
        end
        check("bp accepted", 64'(nacc), 64'd4);
        check("bp req_ready low", 64'(a_req_ready), 64'd0);
        check("bp rsp head", 64'(a_rsp_rdata), 64'(bp_exp[0]));
        @(posedge clk);
        @(negedge clk);
        check("bp head stable vld", 64'(a_rsp_valid), 64'd1);
        check("bp head stable dat", 64'(a_rsp_rdata), 64'(bp_exp[0]));
        a_rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 6; c++) begin
            rdy_s = a_req_ready;
            if (c == 1) check("bp ready recovers", 64'(rdy_s), 64'd1);
            if (a_rsp_valid) begin
                check($sformatf("bp rsp%0d", nrsp), 64'(a_rsp_rdata), 64'(bp_exp[nrsp]));
                nrsp++;
            end
            if (nacc < 6) drive(0, 0, bp_addr[nacc], 32'h0, 4'h0);
            else          idle();
            @(posedge clk);
            if (rdy_s && a_req_valid && nacc < 6) nacc++;
            @(negedge clk);
        end
        a_rsp_ready = 1'b0;
        idle();
        check("bp total accepted", 64'(nacc), 64'd6);
        check("bp total responses", 64'(nrsp), 64'd6);
        check("coll flag sticky", 64'(coll_flag), 64'd1);

        // Reset with two reads in flight.
        do_req(0, 1, 32'd20, 32'h12345678, 4'hF);
        drive(0, 0, 32'd20, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst req_ready", 64'(a_req_ready), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | a_rsp_valid;
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst no rsp", 64'(seen), 64'd0);
        check("midrst coll cleared", 64'(coll_flag), 64'd0);
        for (int k = 0; k < RSP_DEPTH; k++) begin
            check($sformatf("midrst credit%0d", k), 64'(a_req_ready), 64'd1);
            do_req(0, 0, 32'd20, 32'h0, 4'h0);
        end
        check("midrst credits exhausted", 64'(a_req_ready), 64'd0);
        for (int k = 0; k < RSP_DEPTH; k++) begin
            get_rsp(0, "midrst data", lat, d, e);
            check($sformatf("midrst data%0d", k), 64'(d), 64'h12345678);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cl_bram_dp_ctrl.md
# cl_bram_dp_ctrl

Parametrised dual-port block-RAM controller that replaces the fixed 32-bit, 256-deep, always-enabled dual-port RAM wrapper used by the AXI-Lite register path and the systolic-array operand buffers. Each port gets a valid/ready request channel with byte write strobes and a valid/ready read-response channel with a credit-limited response FIFO. The block also provides configurable read latency, out-of-range detection and deterministic cross-port collision handling. It sits between the AXI-Lite slave / systolic-array sequencer and the inferred RAM array it contains.

## Interface
Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 256: number of words; need not be a power of two.
- ADDR_W, 32: request address width; bits above log2(DEPTH) are range-checked, not truncated.
- RD_LAT, 1: read pipeline stages from the RAM read edge to FIFO write; legal values are 1–3.
- RSP_DEPTH, 4: per-port response FIFO depth, which also sets the credit limit; minimum 2.

Ports. Port A and port B are identical; replace x with a or b:
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous reset, active-high
- x_req_valid  in  1  request valid
- x_req_ready  out  1  request accepted on an edge where valid and ready are both high
- x_req_we  in  1  1 = write, 0 = read
- x_req_addr  in  ADDR_W  word address
- x_req_wdata  in  DATA_W  write data
- x_req_wstrb  in  DATA_W/8  byte write enables
- x_rsp_valid  out  1  read response valid
- x_rsp_ready  in  1  response consumed on an edge where valid and ready are both high
- x_rsp_rdata  out  DATA_W  read data
- x_rsp_err  out  1  response belongs to an out-of-range read
- coll_flag  out  1  sticky: at least one same-address write/write collision has occurred since reset

## Operation
- Credits, per port:
  - Reset value is RSP_DEPTH.
  - Decrements on an accepted read and increments on a response pop; both on the same edge leaves it unchanged.
  - x_req_ready = (credits != 0) && !rst.
  - Writes also require ready but consume no credit.
- Write:
  - For an in-range address, bytes with wstrb=1 are updated at the accept edge.
  - wstrb=0 is a legal no-op.
  - An out-of-range write is silently dropped and produces no response.
- Read:
  - An in-range read samples the RAM at the accept edge and the data travels through RD_LAT stages.
  - An out-of-range read travels the same pipeline, returns rdata=0 with rsp_err=1, and still consumes a credit.
- Same-port semantics: the RAM is read-first, so a read returns the word as it was before any write on the same edge.
- Cross-port, same in-range address, same edge:
  - Write/write: port A's write is applied, port B's write is dropped entirely (all bytes), and coll_flag is set.
  - Read/write: the read returns old data and no flag is raised.
  - Read/read: both reads return the same data.
- Response FIFO:
  - First-word-fall-through.
  - Cannot overflow, because credits bound the in-flight reads plus the FIFO occupancy to RSP_DEPTH.
  - Responses on a port leave in request order.
- Reset:
  - Clears all pipeline valids, both FIFOs, credits (to RSP_DEPTH) and coll_flag.
  - In-flight reads are discarded with no response.
  - RAM contents are not cleared.
- Reset values of outputs: x_req_ready=0 while rst=1 and 1 on the first cycle after; x_rsp_valid=0, x_rsp_rdata=0, x_rsp_err=0, coll_flag=0.

## Timing
- Read accepted at edge k: with the FIFO empty, x_rsp_valid goes high after edge k+RD_LAT, with rdata and err stable.
- Back-to-back reads, one per cycle per port, sustain full throughput while rsp_ready=1 and RSP_DEPTH ≥ RD_LAT+1.
- With rsp_ready=0, exactly RSP_DEPTH reads are accepted, then req_ready drops the cycle after the RSP_DEPTH-th accept.
- req_ready recovers the cycle after the first pop.
- rsp_valid, rdata and err are held stable while rsp_valid=1 and rsp_ready=0.
- A write at edge k is visible to a read on either port accepted at edge k+1 or later.
- No combinational path from x_rsp_ready or x_req_valid to x_req_ready. The credit counter is registered, and pops update it at the edge.

## Test plan
- **Basic write then read:** Port A writes 0xDEADBEEF to address 5 with wstrb=4'hF, then reads address 5 at the next edge. Required: rsp_valid after RD_LAT edges, rdata=0xDEADBEEF, err=0.
- **Byte strobes:** Address 7 holds 0x11223344. Port B writes 0xAABBCCDD with wstrb=4'b0101. Required: a read of address 7 returns 0x11BB33DD.
- **Out-of-range:** DEPTH=256. Read address 300. Required: rdata=0, err=1. Then write address 300 and read addresses 300 mod 256 = 44. Required: address 44 is unchanged.
- **Collision:** On the same edge, A writes 0x1 and B writes 0x2 to address 9, while a third read is in flight. Required: address 9 reads 0x1, coll_flag=1 and stays 1 until rst.
- **Backpressure:** RSP_DEPTH=4, hold rsp_ready=0, drive 6 read requests. Required: 4 accepted, req_ready=0. Release rsp_ready. Required: 4 in-order responses, then the remaining 2 are accepted.
- **Reset mid-flight:** Accept 2 reads, assert rst for 1 cycle before they emerge. Required: no rsp_valid, credits back to RSP_DEPTH, previously written RAM data intact.
